async_multi_sync: RTL and testbench
===================================

# async_multi_sync

Parametrised multi-channel level synchroniser for slow, long-held asynchronous control signals: interrupt lines, external handshake levels and strap/status pins. Each channel passes through an N-stage flop chain into the `clk` domain. Per channel, the block also produces a synchronised level, single-cycle rise/fall pulses and an optional glitch filter. It sits at the boundary between pad- or foreign-clock-domain signals and the core, and replaces the single-bit two-flop synchroniser wherever multiple channels, edge detection or filtering are needed.

## Interface
- `CH_NUM`, 4, number of independent channels (≥1).
- `SYNC_STAGES`, 2, synchroniser flops per channel (≥2).
- `RST_VAL`, {CH_NUM{1'b0}}, per-channel reset level of every chain flop and `sync_o`.
- `FILTER_CYC`, 4, consecutive stable cycles required before the filtered level changes (≥1); used only with the filter compiled in.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `async_i`  in  CH_NUM  asynchronous inputs; each must hold a level ≥ SYNC_STAGES+FILTER_CYC+1 `clk` periods.
- `sync_o`  out  CH_NUM  synchronised (optionally filtered) level.
- `rise_o`  out  CH_NUM  one-cycle pulse on 0→1 of `sync_o`.
- `fall_o`  out  CH_NUM  one-cycle pulse on 1→0 of `sync_o`.
- `edge_o`  out  CH_NUM  `rise_o | fall_o`.

## Operation
- Per channel: chain `s[0..SYNC_STAGES-1]`, each stage shifts every `clk` edge: `s[0]<=async_i`, `s[k]<=s[k-1]`. The chain output is `s[SYNC_STAGES-1]`.
- The level register `lvl` drives `sync_o`.
  - Filter out: `lvl` is the chain output itself, with no extra flop.
  - Filter in: `lvl` is the filter register (see Configuration).
- `prev` register: `prev<=lvl` every cycle.
- Edge outputs are combinational from registers only:
  - `rise_o = lvl & ~prev`
  - `fall_o = ~lvl & prev`
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous independent pulses.
- Reset values:
  - All chain flops, `lvl` and `prev` take `RST_VAL`.
  - All counters take 0.
  - Hence `sync_o=RST_VAL` and `rise_o=fall_o=edge_o=0`.
- No pulse is generated by reset assertion or deassertion, even if `async_i≠RST_VAL` at release. The difference propagates as a normal edge after the usual latency.
- Reset mid-operation aborts in-flight chain and filter state immediately. No partial pulse may appear.

## Timing
- Filter out: an input level stable before edge E appears on `sync_o` after edge E+SYNC_STAGES-1, i.e. SYNC_STAGES edges. `rise_o`/`fall_o` are high for exactly that one cycle.
- Filter in: add exactly FILTER_CYC cycles of latency.
- Glitches:
  - Filter out: a glitch shorter than one period may or may not appear.
  - Filter in: a chain-output pulse shorter than FILTER_CYC cycles never reaches `sync_o`.
- Back-to-back changes one cycle apart on the chain output (filter out) yield consecutive `rise_o` then `fall_o` pulses.

## Configuration
- Macro: `ASYNC_MULTI_SYNC_FILTER_EN`.
- Defined: each channel gets a counter `cnt` of width `$clog2(FILTER_CYC)` (minimum 1 bit).
  - If chain output == `lvl`: `cnt<=0`.
  - Otherwise, if `cnt==FILTER_CYC-1`: `lvl<=chain output`, `cnt<=0`.
  - Otherwise: `cnt<=cnt+1`.
  - The counter never wraps past FILTER_CYC-1.
- Undefined: no counters or filter flops exist, `FILTER_CYC` is ignored, and `lvl` is the chain output.

## Structure
- Shared package/header `async_pkg`:
  - default values for SYNC_STAGES and FILTER_CYC
  - a `clog2` helper function
  - nothing block-specific beyond those defaults
- Sub-module `async_sync_chain`:
  - one channel: parametrised SYNC_STAGES and reset bit
  - instantiated CH_NUM times by generate
- Filter, `prev` and edge logic live in the top module.

## Test plan
- Reset: hold `rst_n=0` with `async_i=4'b1111` and `RST_VAL=0` → all outputs 0. Release → `sync_o=4'b1111` after exactly SYNC_STAGES edges (filter out) with a single `rise_o=4'b1111` pulse; no pulse at release itself.
- Latency, filter out, SYNC_STAGES=3: set ch2 to 1 before edge 10 → `sync_o[2]` rises after edge 12, `rise_o[2]` high for that cycle only; at 0 → `fall_o[2]` is the mirror.
- Filter in, FILTER_CYC=4: a 3-cycle high pulse on ch0 at chain output → `sync_o[0]` stays 0 with no pulses. A 4-cycle pulse → `sync_o[0]` high for 4 cycles, delayed by SYNC_STAGES+4.
- Independence: ch0 rises and ch3 falls in the same cycle → `rise_o=4'b0001` and `fall_o=4'b1000` in the same cycle, `edge_o=4'b1001`.
- Reset mid-filter: assert `rst_n` while `cnt=2` → counter 0, `sync_o=RST_VAL`, and no pulse on release until a fresh full FILTER_CYC of stable input.
- Random long-level stimulus (hold ≥ SYNC_STAGES+FILTER_CYC+1) → scoreboard checks every input transition yields exactly one matching pulse.

Source files
------------

// File: rtl/async_pkg.sv
// rtl/async_pkg.sv - shared defaults and helpers for asynchronous-input synchronisers
package async_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILTER_CYC  = 4;

    // Ceiling log2, never narrower than one bit so counters stay declarable.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/async_sync_chain.sv
// rtl/async_sync_chain.sv - single-channel N-stage flop synchroniser with configurable reset bit
module async_sync_chain
    import async_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RST_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= {SYNC_STAGES{RST_BIT}};
        end else begin
            s <= {s[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = s[SYNC_STAGES-1];

endmodule

// File: rtl/async_multi_sync.sv
// rtl/async_multi_sync.sv - multi-channel level synchroniser with edge pulses
// Optional glitch filter compiled in with ASYNC_MULTI_SYNC_FILTER_EN.
module async_multi_sync
    import async_pkg::*;
#(
    parameter int                CH_NUM      = 4,
    parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [CH_NUM-1:0] RST_VAL     = {CH_NUM{1'b0}},
    parameter int                FILTER_CYC  = DEF_FILTER_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] async_i,
    output logic [CH_NUM-1:0] sync_o,
    output logic [CH_NUM-1:0] rise_o,
    output logic [CH_NUM-1:0] fall_o,
    output logic [CH_NUM-1:0] edge_o
);

    if (CH_NUM < 1) begin : g_bad_ch_num
        $error("async_multi_sync: CH_NUM must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("async_multi_sync: SYNC_STAGES must be at least 2");
    end
    if (FILTER_CYC < 1) begin : g_bad_filter_cyc
        $error("async_multi_sync: FILTER_CYC must be at least 1");
    end

    logic [CH_NUM-1:0] chain_out;
    logic [CH_NUM-1:0] lvl;
    logic [CH_NUM-1:0] prev;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        async_sync_chain #(
            .SYNC_STAGES (SYNC_STAGES),
            .RST_BIT     (RST_VAL[g])
        ) u_chain (
            .clk     (clk),
            .rst_n   (rst_n),
            .async_i (async_i[g]),
            .sync_o  (chain_out[g])
        );

`ifdef ASYNC_MULTI_SYNC_FILTER_EN
        localparam int CNT_W = clog2(FILTER_CYC);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYC - 1);

        logic [CNT_W-1:0] cnt;
        logic             lvl_r;

        // The counter only advances while the chain disagrees with the filtered
        // level, so any disagreement shorter than FILTER_CYC cycles is dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                lvl_r <= RST_VAL[g];
            end else if (chain_out[g] == lvl_r) begin
                cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                lvl_r <= chain_out[g];
            end else begin
                cnt   <= cnt + 1'b1;
            end
        end

        assign lvl[g] = lvl_r;
`else
        assign lvl[g] = chain_out[g];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= RST_VAL;
        end else begin
            prev <= lvl;
        end
    end

    // lvl and prev share a reset value, so reset entry and exit never pulse.
    assign sync_o = lvl;
    assign rise_o = lvl & ~prev;
    assign fall_o = ~lvl & prev;
    assign edge_o = rise_o | fall_o;

endmodule

// File: tb/tb_async_multi_sync.sv
// tb/tb_async_multi_sync.sv - self-checking bench for async_multi_sync
module tb_async_multi_sync;

    localparam int CH = 4;
    localparam int SS = 3;
    localparam int FC = 4;
`ifdef ASYNC_MULTI_SYNC_FILTER_EN
    localparam int FL = FC;
`else
    localparam int FL = 0;
`endif
    localparam int LAT = SS + FL;
    localparam logic [CH-1:0] RST_V = 4'b0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] async_i = '0;
    logic [CH-1:0] sync_o, rise_o, fall_o, edge_o;

    async_multi_sync #(
        .CH_NUM      (CH),
        .SYNC_STAGES (SS),
        .RST_VAL     (RST_V),
        .FILTER_CYC  (FC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (async_i),
        .sync_o  (sync_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .edge_o  (edge_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int ch;
        bit rise;
    } ev_t;

    ev_t           sbq[$];
    ev_t           keep[$];
    logic [CH-1:0] model_lvl = RST_V;
    logic [CH-1:0] er, ef;
    bit            sb_on = 1'b0;
    int            total = 0;
    int            bad = 0;

    // Scoreboard: every cycle, pulses due now must appear and nothing else may.
    always begin
        @(posedge clk);
        #1;
        if (sb_on) begin
            er = '0;
            ef = '0;
            if (rst_n !== 1'b1) begin
                sbq.delete();
                model_lvl = RST_V;
            end else begin
                keep.delete();
                foreach (sbq[i]) begin
                    if (sbq[i].due == cyc) begin
                        if (sbq[i].rise) er[sbq[i].ch] = 1'b1;
                        else             ef[sbq[i].ch] = 1'b1;
                    end else if (sbq[i].due < cyc) begin
                        total++;
                        bad++;
                        $display("FAIL sb_missed ch=%0d due=%0d now=%0d", sbq[i].ch, sbq[i].due, cyc);
                    end else begin
                        keep.push_back(sbq[i]);
                    end
                end
                sbq = keep;
                model_lvl = (model_lvl | er) & ~ef;
            end
            total++;
            if ({sync_o, rise_o, fall_o, edge_o} !== {model_lvl, er, ef, er | ef}) begin
                bad++;
                $display("FAIL sb_cycle cyc=%0d got sync=%b rise=%b fall=%b edge=%b want sync=%b rise=%b fall=%b edge=%b",
                         cyc, sync_o, rise_o, fall_o, edge_o, model_lvl, er, ef, er | ef);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_obs(input int n);
        while (1) begin
            @(posedge clk);
            #2;
            if (cyc >= n) break;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [CH-1:0] v, output int t);
        @(negedge clk);
        t = cyc;
        for (int c = 0; c < CH; c++) begin
            if (v[c] !== async_i[c]) sbq.push_back('{t + LAT, c, v[c]});
        end
        async_i = v;
    endtask

    task automatic drive_pulse(input int c, input int w, output int t);
        logic lv;
        @(negedge clk);
        t = cyc;
        lv = async_i[c];
        if (FL == 0 || w >= FC) begin
            sbq.push_back('{t + LAT, c, ~lv});
            sbq.push_back('{t + w + LAT, c, lv});
        end
        async_i[c] = ~lv;
        repeat (w) @(negedge clk);
        async_i[c] = lv;
    endtask

    task automatic test_reset;
        int t;
        sb_on = 1'b1;
        rst_n = 1'b0;
        async_i = 4'b1111;
        idle(4);
        total++;
        if ({sync_o, rise_o, fall_o, edge_o} !== 16'h0) begin
            bad++;
            $display("FAIL reset_hold got %h want 0000", {sync_o, rise_o, fall_o, edge_o});
        end
        rst_n = 1'b1;
        t = cyc;
        for (int c = 0; c < CH; c++) sbq.push_back('{t + LAT, c, 1'b1});
        wait_obs(t + LAT - 1);
        total++;
        if (sync_o !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release_early got %b want 0000", sync_o);
        end
        wait_obs(t + LAT);
        total++;
        if (rise_o !== 4'b1111) begin
            bad++;
            $display("FAIL reset_release_rise got %b want 1111", rise_o);
        end
        idle(4);
    endtask

    task automatic test_latency;
        int t;
        drive(4'b0000, t);
        idle(LAT + 4);
        drive(4'b0100, t);
        wait_obs(t + LAT - 1);
        total++;
        if (sync_o[2] !== 1'b0) begin
            bad++;
            $display("FAIL latency_early got %b want 0", sync_o[2]);
        end
        wait_obs(t + LAT);
        total++;
        if (rise_o !== 4'b0100 || sync_o[2] !== 1'b1) begin
            bad++;
            $display("FAIL latency_rise got rise=%b sync=%b want rise=0100 sync=1", rise_o, sync_o[2]);
        end
        wait_obs(t + LAT + 1);
        total++;
        if (rise_o !== 4'b0000) begin
            bad++;
            $display("FAIL latency_rise_width got %b want 0000", rise_o);
        end
        idle(4);
        drive(4'b0000, t);
        wait_obs(t + LAT);
        total++;
        if (fall_o !== 4'b0100 || sync_o[2] !== 1'b0) begin
            bad++;
            $display("FAIL latency_fall got fall=%b sync=%b want fall=0100 sync=0", fall_o, sync_o[2]);
        end
        idle(4);
    endtask

    task automatic test_independence;
        int t;
        drive(4'b1000, t);
        idle(LAT + 4);
        drive(4'b0001, t);
        wait_obs(t + LAT);
        total++;
        if (rise_o !== 4'b0001 || fall_o !== 4'b1000 || edge_o !== 4'b1001) begin
            bad++;
            $display("FAIL independence got rise=%b fall=%b edge=%b want 0001 1000 1001", rise_o, fall_o, edge_o);
        end
        idle(4);
    endtask

    task automatic test_back_to_back;
        int t;
        logic exp_f;
        drive_pulse(1, 1, t);
        exp_f = (FL == 0);
        wait_obs(t + LAT + 1);
        total++;
        if (fall_o[1] !== exp_f) begin
            bad++;
            $display("FAIL b2b_fall got %b want %b", fall_o[1], exp_f);
        end
        idle(LAT + 4);
        drive_pulse(0, 3, t);
        wait_obs(t + LAT + 1);
        total++;
        if (sync_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL glitch3_level got %b want 0", sync_o[0]);
        end
        idle(LAT + 6);
        drive_pulse(2, 4, t);
        idle(LAT + 8);
    endtask

    task automatic test_reset_mid;
        int t;
        int r;
        drive(async_i | 4'b0010, t);
        wait_obs(t + SS + 2);
        @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        model_lvl = RST_V;
        #1;
        total++;
        if ({sync_o, edge_o} !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid got sync=%b edge=%b want 0000 0000", sync_o, edge_o);
        end
        idle(3);
        rst_n = 1'b1;
        r = cyc;
        for (int c = 0; c < CH; c++) begin
            if (async_i[c]) sbq.push_back('{r + LAT, c, 1'b1});
        end
        wait_obs(r + LAT - 1);
        total++;
        if (sync_o !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_release got %b want 0000", sync_o);
        end
        idle(6);
    endtask

    task automatic test_random;
        int t;
        for (int i = 0; i < 40; i++) begin
            drive(4'($urandom_range(0, 15)), t);
            idle($urandom_range(SS + FC + 1, SS + FC + 7));
        end
        idle(LAT + 3);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL random_drain got %0d pending want 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_independence();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
